// File: rtl/fp_mul_pkg.sv
// Shared FP32 field layout, class-flag positions and the classifier used on multiplier results.
package fp_mul_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef struct packed {
        logic             sgn;
        logic [EXP_W-1:0] expo;
        logic [MAN_W-1:0] mant;
    } fp_t;

    function automatic logic [2:0] fp_classify(input logic [FP_W-1:0] v);
        fp_t f;
        f = v;
        fp_classify = '0;
        fp_classify[FLAG_NAN]  = (f.expo == '1) && (f.mant != '0);
        fp_classify[FLAG_INF]  = (f.expo == '1) && (f.mant == '0);
        fp_classify[FLAG_ZERO] = (f.expo == '0) && (f.mant == '0);
    endfunction

endpackage

// File: rtl/fp_mul_sched_if.sv
// Requester operand channels plus the shared tagged response channel of the multiplier scheduler.
interface fp_mul_sched_if
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [FP_W*N_REQ-1:0] req_a;
    logic [FP_W*N_REQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [FP_W-1:0]       resp_data;
    logic [2:0]            resp_flags;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_flags, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_flags, busy
    );

endinterface

// File: rtl/MUL.sv
// Combinational FP32 multiplier, round-to-nearest-even; subnormal inputs and underflow flush to zero.
module MUL
    import fp_mul_pkg::*;
(
    input  logic [FP_W-1:0] in1,
    input  logic [FP_W-1:0] in2,
    output logic [FP_W-1:0] out
);

    fp_t               a, b;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              sgn, inc;
    logic [47:0]       prod;
    logic [MAN_W-1:0]  man;
    logic [MAN_W:0]    rnd;
    logic signed [9:0] e;

    assign a = in1;
    assign b = in2;

    always_comb begin
        out    = '0;
        a_nan  = (a.expo == '1) && (a.mant != '0);
        b_nan  = (b.expo == '1) && (b.mant != '0);
        a_inf  = (a.expo == '1) && (a.mant == '0);
        b_inf  = (b.expo == '1) && (b.mant == '0);
        a_zero = (a.expo == '0);
        b_zero = (b.expo == '0);
        sgn    = a.sgn ^ b.sgn;
        prod   = 48'({1'b1, a.mant}) * 48'({1'b1, b.mant});
        e      = $signed({2'b00, a.expo}) + $signed({2'b00, b.expo}) - 10'sd127;
        // Product of two [1,2) significands lies in [1,4); bit 47 selects the renormalising shift.
        if (prod[47]) begin
            man = prod[46:24];
            inc = prod[23] && ((|prod[22:0]) || prod[24]);
            e   = e + 10'sd1;
        end else begin
            man = prod[45:23];
            inc = prod[22] && ((|prod[21:0]) || prod[23]);
        end
        rnd = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        man = rnd[MAN_W-1:0];
        if (rnd[MAN_W]) begin
            e = e + 10'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            out = 32'h7FC0_0000;
        end else if (a_inf || b_inf || (e >= 10'sd255)) begin
            out = {sgn, 8'hFF, 23'h0};
        end else if (a_zero || b_zero || (e <= 10'sd0)) begin
            out = {sgn, 31'h0};
        end else begin
            out = {sgn, e[7:0], man};
        end
    end

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, scanning upward mod N.
// Latency 0; no state, the caller owns the pointer.
module rr_arb #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler feeding one shared FP32 multiplier through an operand stage and a response stage.
// Latency 2 cycles accept-to-resp_valid; 1 accept/cycle; a held response stalls S2, then S1, then all req_ready.
module fp_mul_sched
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input logic           clk,
    input logic           rst,
    fp_mul_sched_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);

    logic             s1_valid;
    logic [FP_W-1:0]  s1_a, s1_b;
    logic [ID_W-1:0]  s1_id;
    logic [ID_W-1:0]  rr_ptr;
    logic             resp_valid;
    logic [FP_W-1:0]  resp_data;
    logic [ID_W-1:0]  resp_id;
    logic [2:0]       resp_flags;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic [FP_W-1:0]  mul_out;
    logic             adv1, adv2, accept;
    logic [ID_W-1:0]  ptr_next;

    rr_arb #(.N(N_REQ)) u_arb (
        .req      (bus.req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    MUL u_mul (
        .in1 (s1_a),
        .in2 (s1_b),
        .out (mul_out)
    );

    assign adv2          = !resp_valid || bus.resp_ready;
    assign adv1          = !s1_valid || adv2;
    assign bus.req_ready = adv1 ? grant : '0;
    // grant is only ever set for an asserted req_valid, so a live grant plus adv1 is a handshake.
    assign accept        = adv1 && (|grant);
    assign ptr_next      = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_flags <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_a   <= bus.req_a[int'(grant_id)*FP_W +: FP_W];
                    s1_b   <= bus.req_b[int'(grant_id)*FP_W +: FP_W];
                    s1_id  <= grant_id;
                    rr_ptr <= ptr_next;
                end
            end
            if (adv2) begin
                resp_valid <= s1_valid;
                resp_data  <= mul_out;
                resp_id    <= s1_id;
                resp_flags <= fp_classify(mul_out);
            end
        end
    end

    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_data;
    assign bus.resp_id    = resp_id;
    assign bus.resp_flags = resp_flags;
    assign bus.busy       = s1_valid || resp_valid;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Bench for fp_mul_sched: directed scenarios plus randomized streams checked against a transaction-level model.
module tb_fp_mul_sched;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    fp_mul_sched_if #(.N_REQ(4)) bus ();

    fp_mul_sched #(.N_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          stage;
    } ent_t;

    // Exact float encoding of a small non-negative integer (products here stay well inside 24 bits).
    function automatic logic [31:0] int_to_fp(input int unsigned n);
        int          e;
        int unsigned m;
        logic [31:0] mm;
        if (n == 0) return 32'h0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m  = n * (32'd1 << (23 - e));
        mm = m;
        return {1'b0, 8'(127 + e), mm[22:0]};
    endfunction

    function automatic int model_grant(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        tick();
        tick();
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.resp_data !== 32'h0) begin fails++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
        tests++; if (bus.resp_id !== 2'd0) begin fails++; $display("FAIL reset_resp_id: got %0d expected 0", bus.resp_id); end
        tests++; if (bus.resp_flags !== 3'b000) begin fails++; $display("FAIL reset_resp_flags: got %b expected 000", bus.resp_flags); end
        tests++; if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
        rst = 1'b0;
        bus.req_valid = 4'b1110;
        #1;
        tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL reset_lowest_grant: got %b expected 0010", bus.req_ready); end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        bus.req_a[31:0] = 32'h4000_0000;
        bus.req_b[31:0] = 32'h3F80_0000;
        bus.req_valid   = 4'b0001;
        #1;
        tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL single_early: resp_valid got %b expected 0", bus.resp_valid); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        tick();
        tests++; if (bus.resp_valid !== 1'b1) begin fails++; $display("FAIL single_latency: resp_valid got %b expected 1", bus.resp_valid); end
        tests++; if (bus.resp_data !== 32'h4000_0000) begin fails++; $display("FAIL single_data: got %h expected 40000000", bus.resp_data); end
        tests++; if (bus.resp_id !== 2'd0) begin fails++; $display("FAIL single_id: got %0d expected 0", bus.resp_id); end
        tests++; if (bus.resp_flags !== 3'b000) begin fails++; $display("FAIL single_flags: got %b expected 000", bus.resp_flags); end
        tick();
        tests++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL single_drain: resp_valid/busy got %b%b expected 00", bus.resp_valid, bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_d [4];
        logic [2:0]  exp_f [4];
        logic [3:0]  exp_r;
        int          j;
        exp_d[0] = 32'h4000_0000; exp_f[0] = 3'b000;
        exp_d[1] = 32'h410C_0000; exp_f[1] = 3'b000;
        exp_d[2] = 32'h0;         exp_f[2] = 3'b100;
        exp_d[3] = 32'h7F80_0000; exp_f[3] = 3'b010;
        rst = 1'b1;
        bus.resp_ready = 1'b1;
        bus.req_a = {32'h7F80_0000, 32'h7F80_0000, 32'h4020_0000, 32'h4000_0000};
        bus.req_b = {32'h7F80_0000, 32'h0000_0000, 32'h4060_0000, 32'h3F80_0000};
        bus.req_valid = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = (k < 5) ? 4'hF : 4'h0;
            #1;
            if (k < 5) begin
                exp_r = 4'(1 << (k % 4));
                tests++; if (bus.req_ready !== exp_r) begin fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_r); end
            end
            if (k >= 2 && k <= 6) begin
                j = (k - 2) % 4;
                tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(j)) begin fails++; $display("FAIL rr_resp_id[%0d]: valid %b id %0d expected valid 1 id %0d", k, bus.resp_valid, bus.resp_id, j); end
                if (j != 2) begin
                    tests++; if (bus.resp_data !== exp_d[j]) begin fails++; $display("FAIL rr_resp_data[%0d]: got %h expected %h", k, bus.resp_data, exp_d[j]); end
                end
                tests++; if (bus.resp_flags !== exp_f[j]) begin fails++; $display("FAIL rr_resp_flags[%0d]: got %b expected %b", k, bus.resp_flags, exp_f[j]); end
            end
            if (k == 7) begin
                tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rr_extra_resp: resp_valid got %b expected 0", bus.resp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_stream(input int ncyc, input bit stall, input bit rand_ready);
        ent_t        q[$];
        ent_t        ent;
        logic [3:0]  pv;
        int unsigned pa [4];
        int unsigned pb [4];
        int          ptr_m;
        int          g;
        bit          head_vis, s1_full, adv1, adv2;
        logic [3:0]  exp_r;
        logic [2:0]  exp_f;
        int          n_acc, n_resp;
        apply_reset();
        pv = '0; ptr_m = 0; n_acc = 0; n_resp = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && c < ncyc - 12 && (stall || $urandom_range(0, 3) != 0)) begin
                    pa[i] = $urandom_range(0, 300);
                    pb[i] = $urandom_range(0, 300);
                    pv[i] = 1'b1;
                    bus.req_a[32*i +: 32] = int_to_fp(pa[i]);
                    bus.req_b[32*i +: 32] = int_to_fp(pb[i]);
                end
            end
            bus.req_valid = pv;
            if (stall && c >= 6 && c < 11) bus.resp_ready = 1'b0;
            else if (rand_ready && c < ncyc - 12) bus.resp_ready = ($urandom_range(0, 3) != 0);
            else bus.resp_ready = 1'b1;
            #1;
            head_vis = (q.size() > 0) && (q[0].stage == 2);
            s1_full  = (q.size() > 0) && (q[q.size()-1].stage == 1);
            adv2     = !head_vis || bus.resp_ready;
            adv1     = !s1_full || adv2;
            g        = model_grant(pv, ptr_m);
            exp_r    = (g >= 0 && adv1) ? 4'(1 << g) : 4'b0;
            tests++; if (bus.req_ready !== exp_r) begin fails++; $display("FAIL stream_ready[c%0d]: got %b expected %b", c, bus.req_ready, exp_r); end
            tests++; if (bus.resp_valid !== head_vis) begin fails++; $display("FAIL stream_resp_valid[c%0d]: got %b expected %b", c, bus.resp_valid, head_vis); end
            tests++; if (dut.rr_ptr !== 2'(ptr_m)) begin fails++; $display("FAIL stream_rr_ptr[c%0d]: got %0d expected %0d", c, dut.rr_ptr, ptr_m); end
            tests++; if (bus.busy !== (q.size() > 0)) begin fails++; $display("FAIL stream_busy[c%0d]: got %b expected %b", c, bus.busy, q.size() > 0); end
            if (head_vis) begin
                exp_f = (q[0].data == 32'h0) ? 3'b001 : 3'b000;
                tests++;
                if (bus.resp_id !== 2'(q[0].id) || bus.resp_data !== q[0].data || bus.resp_flags !== exp_f) begin
                    fails++;
                    $display("FAIL stream_resp[c%0d]: got id %0d data %h flags %b expected id %0d data %h flags %b",
                             c, bus.resp_id, bus.resp_data, bus.resp_flags, q[0].id, q[0].data, exp_f);
                end
            end
            if (head_vis && bus.resp_ready) begin
                void'(q.pop_front());
                n_resp++;
            end
            if (adv2) begin
                foreach (q[i]) q[i].stage = 2;
            end
            if (exp_r != 4'b0) begin
                ent.id    = g;
                ent.data  = int_to_fp(pa[g] * pb[g]);
                ent.stage = 1;
                q.push_back(ent);
                pv[g] = 1'b0;
                ptr_m = (g + 1) % 4;
                n_acc++;
            end
            tick();
        end
        tests++; if (n_resp != n_acc || q.size() != 0) begin fails++; $display("FAIL stream_count: responses %0d expected %0d (left %0d)", n_resp, n_acc, q.size()); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL stream_idle: busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_sparse();
        int unsigned pa [4];
        int unsigned pb [4];
        logic [3:0]  exp_r [3];
        int          exp_id [3];
        apply_reset();
        bus.req_valid = 4'b0010;
        #1;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            pa[i] = $urandom_range(1, 255);
            pb[i] = $urandom_range(1, 255);
            bus.req_a[32*i +: 32] = int_to_fp(pa[i]);
            bus.req_b[32*i +: 32] = int_to_fp(pb[i]);
        end
        exp_r[0] = 4'b1000; exp_r[1] = 4'b0010; exp_r[2] = 4'b1000;
        exp_id[0] = 3; exp_id[1] = 1; exp_id[2] = 3;
        for (int k = 0; k < 6; k++) begin
            bus.req_valid = (k < 3) ? 4'b1010 : 4'b0000;
            #1;
            if (k < 3) begin
                tests++; if (bus.req_ready !== exp_r[k]) begin fails++; $display("FAIL sparse_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_r[k]); end
            end
            if (k >= 2 && k < 5) begin
                tests++;
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(exp_id[k-2]) || bus.resp_data !== int_to_fp(pa[exp_id[k-2]] * pb[exp_id[k-2]])) begin
                    fails++;
                    $display("FAIL sparse_resp[%0d]: valid %b id %0d data %h expected id %0d data %h", k, bus.resp_valid, bus.resp_id,
                             bus.resp_data, exp_id[k-2], int_to_fp(pa[exp_id[k-2]] * pb[exp_id[k-2]]));
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.resp_ready  = 1'b0;
        bus.req_a[31:0] = int_to_fp(7);
        bus.req_b[31:0] = int_to_fp(9);
        bus.req_valid   = 4'b0001;
        tick();
        tick();
        bus.req_valid = '0;
        #1;
        tests++; if (bus.resp_valid !== 1'b1 || dut.s1_valid !== 1'b1) begin fails++; $display("FAIL arst_fill: resp_valid %b s1_valid %b expected 1 1", bus.resp_valid, dut.s1_valid); end
        #1;
        rst = 1'b1;
        #1;
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL arst_resp_valid: got %b expected 0", bus.resp_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
        tests++; if (dut.s1_valid !== 1'b0) begin fails++; $display("FAIL arst_s1_valid: got %b expected 0", dut.s1_valid); end
        #1;
        rst = 1'b0;
        bus.resp_ready   = 1'b1;
        bus.req_a[95:64] = int_to_fp(12);
        bus.req_b[95:64] = int_to_fp(11);
        bus.req_valid    = 4'b0100;
        #1;
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL arst_post_ready: got %b expected 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL arst_stale: resp_valid got %b expected 0", bus.resp_valid); end
        tick();
        tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_data !== int_to_fp(132)) begin
            fails++;
            $display("FAIL arst_first_resp: valid %b id %0d data %h expected 1 2 %h", bus.resp_valid, bus.resp_id, bus.resp_data, int_to_fp(132));
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_stream(40, 1'b1, 1'b0);
        test_stream(300, 1'b0, 1'b1);
        test_sparse();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mul_sched.md
# fp_mul_sched

Round-robin scheduler that shares one combinational single-precision multiplier (`MUL`, ports `in1`/`in2`/`out`) among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues them into a 2-stage registered pipeline around `MUL`. Results return on one shared response channel tagged with the requester ID and IEEE-754 class flags. It sits between the FP-using clients and the single `MUL` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(N_REQ)`: response tag width (derived, do not override).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  32*N_REQ  operand A, requester i in bits [32i+31:32i].
- `req_b`  in  32*N_REQ  operand B, same packing.
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  ID_W  index of the requester that issued the result.
- `resp_data`  out  32  product from `MUL`.
- `resp_flags`  out  3  {nan, inf, zero}, classified from `resp_data`.
- `busy`  out  1  high when either pipeline stage holds valid data.

## Operation
- Stage 1 (S1) holds `s1_valid`, `s1_a`, `s1_b`, `s1_id`. `MUL` is driven combinationally from `s1_a`/`s1_b`.
- Stage 2 (S2) is the response register: `resp_valid`, `resp_data`, `resp_id`, `resp_flags`.
- `adv2 = !resp_valid || resp_ready`. `adv1 = !s1_valid || adv2`.
- Arbitration is combinational. The grant goes to the first asserted `req_valid` at or after `rr_ptr`, scanning upward with modulo `N_REQ`.
- `req_ready[i] = grant[i] && adv1`. It never depends on `req_valid[j]` for any j ≠ i, except through the grant scan.
- Accept happens when `req_valid[g] && req_ready[g]`. S1 loads the operands and ID of requester g, and `rr_ptr` moves to (g+1) mod `N_REQ`, wrapping from `N_REQ-1` to 0.
- `rr_ptr` holds when nothing is accepted, including when a grant is blocked by a stall.
- S1 without an accept but with `adv1` asserted: `s1_valid` clears.
- S2 update when `adv2` is asserted: S2 loads `s1_valid`, `out`, `s1_id`, and the flags.
- Stall: when `resp_valid && !resp_ready`, S2 holds, S1 holds if valid, and all `req_ready` are low if S1 is full.
- Flags from `resp_data`:
  - nan = exponent 0xFF and mantissa ≠ 0.
  - inf = exponent 0xFF and mantissa = 0.
  - zero = exponent 0 and mantissa = 0.
  - At most one flag is set.
- The scheduler does no arithmetic or special-case handling. NaN, Inf and zero propagation is entirely `MUL` behaviour.
- A requester must hold `req_a`/`req_b` stable while `req_valid` is high and it is not yet accepted. The scheduler does not require this for correctness, because it samples only at accept.

## Timing
- Reset values: `s1_valid`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, `resp_flags`=0, `rr_ptr`=0, `busy`=0. `req_ready` is then high only for the lowest-index requester that asserts `req_valid`.
- Latency: accept at edge E gives `resp_valid` high after edge E+1, i.e. 2 cycles with `resp_ready` held high.
- Throughput: 1 accept per cycle while `resp_ready`=1.
- Simultaneous S2 drain and new accept in the same cycle is allowed. There are no bubbles.
- Reset asserted mid-operation clears both stages immediately, without waiting for a clock. In-flight results are dropped and never reported.
- `resp_*` are stable while `resp_valid && !resp_ready`.

## Structure
- Package `fp_mul_pkg`:
  - constants `FP_W`=32, `EXP_W`=8, `MAN_W`=23.
  - flag indices `FLAG_NAN`=2, `FLAG_INF`=1, `FLAG_ZERO`=0.
  - function `fp_classify(32b) -> 3b`.
- Sub-module `rr_arb` (parameter N): inputs `req`, `ptr`; outputs one-hot `grant` and encoded `grant_id`; purely combinational.
- `MUL` is instantiated once, unchanged.

## Test plan
- Single requester 0 sends 0x40000000 × 0x3F800000 (2.0×1.0). Required: `resp_valid` 2 cycles after accept, `resp_data`=0x40000000, `resp_id`=0, flags=000.
- All 4 requesters are valid continuously starting from reset. Required: grant order 0,1,2,3,0. Requester 1 sends 0x40200000×0x40600000 and must get `resp_data`=0x410C0000 (8.75) with `resp_id`=1.
- Requester 2 sends 0x7F800000×0x00000000 (+Inf×0). Required: `resp_flags`[nan]=1. Requester 3 sends 0x7F800000×0x7F800000. Required: inf=1, `resp_data`=0x7F800000.
- `resp_ready` is held low for 5 cycles during streaming. Required: `resp_*` hold, at most 2 results are in flight, `req_ready` goes low, `rr_ptr` is unchanged, and there is no loss or duplication after release.
- Only requesters 1 and 3 are valid, with `rr_ptr` at 2. Required: 3 is granted, then 1, then 3; requesters 0 and 2 never see `req_ready`.
- `rst` is pulsed between clock edges with both stages full. Required: `resp_valid`, `busy` and `s1_valid` drop immediately, and the first post-reset response is the first post-reset request.
